// File: rtl/config_chain_loader_if.sv
// Host-side bitstream word handshake for config_chain_loader.
interface config_chain_loader_if #(
  parameter int WORD_WIDTH = 8
);
  logic [WORD_WIDTH-1:0] word_data;
  logic                  word_valid;
  logic                  word_ready;

  modport master (output word_data, output word_valid, input  word_ready);
  modport slave  (input  word_data, input  word_valid, output word_ready);
endinterface

// File: rtl/config_chain_loader.sv
// Serialises host bitstream words MSB-first onto the tile config shift chain.
// Optional CONFIG_READBACK_EN streams the displaced chain contents back as readback words.
module config_chain_loader #(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 96,
  parameter int COUNT_WIDTH  = $clog2(CHAIN_LENGTH+1)
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start,
  input  logic                  abort,
  config_chain_loader_if.slave  host,
  output logic                  chain_data,
  output logic                  chain_enable,
  input  logic                  chain_return,
  output logic                  busy,
  output logic                  done
`ifdef CONFIG_READBACK_EN
  ,
  output logic [WORD_WIDTH-1:0] readback_data,
  output logic                  readback_valid
`endif
);
  localparam int NW = $clog2(WORD_WIDTH+1);

  typedef enum logic [1:0] {IDLE, WAIT_WORD, SHIFT, DONE} state_t;

  state_t                 state;
  logic [COUNT_WIDTH-1:0] bits_left;
  logic [NW-1:0]          word_cnt;
  logic [WORD_WIDTH-1:0]  shreg;
  logic                   partial;
  logic                   last_bit;
  logic                   accept;
  logic                   kill;

  // Final word may carry fewer chain bits than a full word; only its top bits go out.
  assign partial  = 32'(bits_left) < WORD_WIDTH;
  assign last_bit = word_cnt == NW'(1);
  assign accept   = host.word_valid && host.word_ready;
  assign kill     = abort && (state != IDLE);

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state           <= IDLE;
      bits_left       <= '0;
      word_cnt        <= '0;
      shreg           <= '0;
      host.word_ready <= 1'b0;
      chain_data      <= 1'b0;
      chain_enable    <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else if (kill) begin
      state           <= IDLE;
      host.word_ready <= 1'b0;
      chain_data      <= 1'b0;
      chain_enable    <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state           <= WAIT_WORD;
          bits_left       <= COUNT_WIDTH'(CHAIN_LENGTH);
          done            <= 1'b0;
          busy            <= 1'b1;
          host.word_ready <= 1'b1;
        end
        WAIT_WORD: if (accept) begin
          state           <= SHIFT;
          shreg           <= host.word_data;
          word_cnt        <= partial ? NW'(bits_left) : NW'(WORD_WIDTH);
          chain_data      <= host.word_data[WORD_WIDTH-1];
          chain_enable    <= 1'b1;
          host.word_ready <= 1'b0;
        end
        SHIFT: begin
          bits_left <= bits_left - COUNT_WIDTH'(1);
          if (last_bit) begin
            chain_enable <= 1'b0;
            chain_data   <= 1'b0;
            if (bits_left == COUNT_WIDTH'(1)) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state           <= WAIT_WORD;
              host.word_ready <= 1'b1;
            end
          end else begin
            word_cnt   <= word_cnt - NW'(1);
            shreg      <= {shreg[WORD_WIDTH-2:0], 1'b0};
            chain_data <= shreg[WORD_WIDTH-2];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CONFIG_READBACK_EN
  localparam int IW = $clog2(WORD_WIDTH);

  logic [WORD_WIDTH-1:0] rb_sr;
  logic [WORD_WIDTH-1:0] rb_next;
  logic [IW-1:0]         rb_idx;

  // Returned bits fill from the MSB down so a short final word comes out left-aligned.
  always_comb begin
    rb_next         = rb_sr;
    rb_next[rb_idx] = chain_return;
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      rb_sr          <= '0;
      rb_idx         <= '0;
      readback_data  <= '0;
      readback_valid <= 1'b0;
    end else begin
      readback_valid <= 1'b0;
      if (kill) begin
        rb_sr <= '0;
      end else if (state == WAIT_WORD && accept) begin
        rb_sr  <= '0;
        rb_idx <= IW'(WORD_WIDTH-1);
      end else if (chain_enable) begin
        rb_idx <= rb_idx - IW'(1);
        if (last_bit) begin
          readback_data  <= rb_next;
          readback_valid <= 1'b1;
        end else begin
          rb_sr <= rb_next;
        end
      end
    end
  end
`else
  logic unused_chain_return;
  assign unused_chain_return = chain_return;
`endif

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench for config_chain_loader: a 96-bit and a 20-bit chain, each with a behavioural shift chain.
module tb_config_chain_loader;
  logic clock = 1'b0;
  logic nreset = 1'b0;
  logic start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
  logic chain_data_a, chain_enable_a, busy_a, done_a;
  logic chain_data_b, chain_enable_b, busy_b, done_b;
  logic [95:0] chain_a = '0;
  logic [19:0] chain_b = '0;
  logic chain_return_a, chain_return_b;

  assign chain_return_a = chain_a[95];
  assign chain_return_b = chain_b[19];

  always #5 clock = ~clock;

  config_chain_loader_if #(.WORD_WIDTH(8)) ifa();
  config_chain_loader_if #(.WORD_WIDTH(8)) ifb();

`ifdef CONFIG_READBACK_EN
  logic [7:0] rb_data_a, rb_data_b;
  logic       rb_valid_a, rb_valid_b;
`endif

  config_chain_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(96)) dut_a (
    .clock(clock), .nreset(nreset), .start(start_a), .abort(abort_a), .host(ifa),
    .chain_data(chain_data_a), .chain_enable(chain_enable_a), .chain_return(chain_return_a),
    .busy(busy_a), .done(done_a)
`ifdef CONFIG_READBACK_EN
    , .readback_data(rb_data_a), .readback_valid(rb_valid_a)
`endif
  );

  config_chain_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(20)) dut_b (
    .clock(clock), .nreset(nreset), .start(start_b), .abort(abort_b), .host(ifb),
    .chain_data(chain_data_b), .chain_enable(chain_enable_b), .chain_return(chain_return_b),
    .busy(busy_b), .done(done_b)
`ifdef CONFIG_READBACK_EN
    , .readback_data(rb_data_b), .readback_valid(rb_valid_b)
`endif
  );

  // Behavioural chains plus enable/burst bookkeeping
  int   en_cnt_a = 0, burst_a = 0, en_cnt_b = 0, burst_b = 0, len_b = 0, nlens_b = 0;
  int   lens_b [0:15];
  int   viol = 0;
  logic en_prev_a = 1'b0, en_prev_b = 1'b0;

  always @(posedge clock) begin
    if (chain_enable_a) begin
      chain_a  <= {chain_a[94:0], chain_data_a};
      en_cnt_a <= en_cnt_a + 1;
    end
    if (chain_enable_a && !en_prev_a) burst_a <= burst_a + 1;
    en_prev_a <= chain_enable_a;
    if (chain_enable_b) begin
      chain_b  <= {chain_b[18:0], chain_data_b};
      en_cnt_b <= en_cnt_b + 1;
      len_b    <= (en_prev_b ? len_b : 0) + 1;
    end
    if (chain_enable_b && !en_prev_b) burst_b <= burst_b + 1;
    if (!chain_enable_b && en_prev_b) begin
      lens_b[nlens_b % 16] <= len_b;
      nlens_b              <= nlens_b + 1;
    end
    en_prev_b <= chain_enable_b;
  end

  always @(negedge clock) begin
    if ((!chain_enable_a && chain_data_a) || (!chain_enable_b && chain_data_b)) viol <= viol + 1;
  end

`ifdef CONFIG_READBACK_EN
  int         rb_cnt_a = 0, rb_err_a = 0, rb_cnt_b = 0;
  logic       rb_chk_a = 1'b0;
  logic [7:0] rb_exp_a = '0;
  logic [7:0] rb_log_b [0:15];
  always @(negedge clock) begin
    if (rb_valid_a) begin
      rb_cnt_a <= rb_cnt_a + 1;
      if (rb_chk_a && rb_data_a !== rb_exp_a) rb_err_a <= rb_err_a + 1;
    end
    if (rb_valid_b) begin
      rb_log_b[rb_cnt_b % 16] <= rb_data_b;
      rb_cnt_b                <= rb_cnt_b + 1;
    end
  end
`endif

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Full load on the 96-bit chain; g idle-valid cycles precede every word.
  task automatic load_a(input logic [7:0] w, input int g, output int done_cyc,
                        output int gap_cnt, output int gap_err, output logic first_ok);
    int words, gapc, n;
    words = 0; gapc = 0; gap_cnt = 0; gap_err = 0;
    start_a = 1'b1;
    @(negedge clock);
    start_a  = 1'b0;
    n        = 1;
    first_ok = busy_a && !done_a && ifa.word_ready;
    while (!done_a && n < 3000) begin
      if (ifa.word_ready && words < 12) begin
        if (gapc < g) begin
          ifa.word_valid = 1'b0;
          gapc++; gap_cnt++;
          if (chain_enable_a) gap_err++;
        end else begin
          ifa.word_valid = 1'b1;
          ifa.word_data  = w;
          words++; gapc = 0;
        end
      end else begin
        ifa.word_valid = 1'b0;
      end
      @(negedge clock);
      n++;
    end
    ifa.word_valid = 1'b0;
    done_cyc = n;
  endtask

  task automatic load_b(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                        output int done_cyc);
    logic [7:0] ws [0:2];
    int words, n;
    ws[0] = w0; ws[1] = w1; ws[2] = w2;
    words = 0;
    start_b = 1'b1;
    @(negedge clock);
    start_b = 1'b0;
    n = 1;
    while (!done_b && n < 500) begin
      if (ifb.word_ready && words < 3) begin
        ifb.word_valid = 1'b1;
        ifb.word_data  = ws[words];
        words++;
      end else begin
        ifb.word_valid = 1'b0;
      end
      @(negedge clock);
      n++;
    end
    ifb.word_valid = 1'b0;
    done_cyc = n;
  endtask

  typedef struct {
    logic [7:0] word;
    int         gap;
    int         exp_done;
    logic [7:0] exp_rb;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [0:3];
    logic [95:0] exp_chain;
    int          dc, gc, ge, e0, b0, n0;
    logic        fo;
`ifdef CONFIG_READBACK_EN
    int          r0, re0;
`endif
    vecs[0] = '{8'hA5, 0, 109, 8'h00};
    vecs[1] = '{8'h3C, 0, 109, 8'hA5};
    vecs[2] = '{8'h00, 5, 169, 8'h3C};
    vecs[3] = '{8'h01, 2, 133, 8'h00};

    ifa.word_valid = 1'b0; ifa.word_data = '0;
    ifb.word_valid = 1'b0; ifb.word_data = '0;
    repeat (3) @(negedge clock);
    nreset = 1'b1;
    @(negedge clock);
    chk("reset_outs_a", {ifa.word_ready, chain_data_a, chain_enable_a, busy_a, done_a}, 5'b0);
    chk("reset_outs_b", {ifb.word_ready, chain_data_b, chain_enable_b, busy_b, done_b}, 5'b0);

    for (int i = 0; i < 4; i++) begin
      e0 = en_cnt_a; b0 = burst_a;
`ifdef CONFIG_READBACK_EN
      r0 = rb_cnt_a; re0 = rb_err_a; rb_exp_a = vecs[i].exp_rb; rb_chk_a = 1'b1;
`endif
      load_a(vecs[i].word, vecs[i].gap, dc, gc, ge, fo);
      exp_chain = {12{vecs[i].word}};
      chk("vec_start_state", fo, 1'b1);
      chk("vec_done_cycle", dc, vecs[i].exp_done);
      chk("vec_enables", en_cnt_a - e0, 96);
      chk("vec_bursts", burst_a - b0, 12);
      chk("vec_chain", chain_a, exp_chain);
      chk("vec_gap_cycles", gc, 12 * vecs[i].gap);
      chk("vec_gap_enable", ge, 0);
      chk("vec_idle_outs", {busy_a, done_a, ifa.word_ready, chain_enable_a}, 4'b0100);
`ifdef CONFIG_READBACK_EN
      @(negedge clock);
      chk("vec_rb_count", rb_cnt_a - r0, 12);
      chk("vec_rb_errors", rb_err_a - re0, 0);
      rb_chk_a = 1'b0;
`endif
    end

    // Words offered in DONE are refused and done holds
    e0 = en_cnt_a;
    ifa.word_valid = 1'b1; ifa.word_data = 8'hFF;
    repeat (3) @(negedge clock);
    chk("done_hold", {done_a, ifa.word_ready}, 2'b10);
    chk("done_no_shift", en_cnt_a - e0, 0);
    ifa.word_valid = 1'b0;

    // start mid-SHIFT ignored; abort on 3rd shift cycle of word 4
    e0 = en_cnt_a;
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    ifa.word_valid = 1'b1; ifa.word_data = 8'h96;
    for (int n = 1; n <= 31; n++) begin
      start_a = (n == 5);
      abort_a = (n == 31);
      if (n == 31) chk("abort_pre_enable", chain_enable_a, 1'b1);
      @(negedge clock);
    end
    abort_a = 1'b0;
    chk("abort_outs", {chain_enable_a, chain_data_a, ifa.word_ready, busy_a, done_a}, 5'b0);
    chk("abort_enables", en_cnt_a - e0, 27);
    repeat (3) @(negedge clock);
    chk("abort_idle_refuse", {ifa.word_ready, chain_enable_a}, 2'b0);
    chk("abort_idle_enables", en_cnt_a - e0, 27);
    ifa.word_valid = 1'b0;

    e0 = en_cnt_a;
    load_a(8'h5A, 0, dc, gc, ge, fo);
    exp_chain = {12{8'h5A}};
    chk("reload_done_cycle", dc, 109);
    chk("reload_enables", en_cnt_a - e0, 96);
    chk("reload_chain", chain_a, exp_chain);

    // Partial final word on the 20-bit chain
    e0 = en_cnt_b; b0 = burst_b; n0 = nlens_b;
    load_b(8'hFF, 8'h00, 8'hC3, dc);
    @(negedge clock);
    chk("part_done_cycle", dc, 24);
    chk("part_enables", en_cnt_b - e0, 20);
    chk("part_bursts", burst_b - b0, 3);
    chk("part_burst_lens", {lens_b[n0 % 16], lens_b[(n0+1) % 16], lens_b[(n0+2) % 16]}, {32'd8, 32'd8, 32'd4});
    chk("part_chain", chain_b, 20'hFF00C);
    chk("part_done_outs", {done_b, busy_b}, 2'b10);
`ifdef CONFIG_READBACK_EN
    r0 = rb_cnt_b;
`endif
    load_b(8'h00, 8'h00, 8'h00, dc);
    @(negedge clock);
    chk("part2_done_cycle", dc, 24);
    chk("part2_chain", chain_b, 20'h0);
`ifdef CONFIG_READBACK_EN
    chk("part2_rb_count", rb_cnt_b - r0, 3);
    chk("part2_rb_data", {rb_log_b[r0 % 16], rb_log_b[(r0+1) % 16], rb_log_b[(r0+2) % 16]}, 24'hFF00C0);
`endif

    // Asynchronous reset while shifting
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    ifa.word_valid = 1'b1; ifa.word_data = 8'hA5;
    for (int n = 0; n < 20 && !chain_enable_a; n++) @(negedge clock);
    chk("rst_pre_enable", chain_enable_a, 1'b1);
    #3 nreset = 1'b0;
    #1;
    chk("rst_async_a", {ifa.word_ready, chain_data_a, chain_enable_a, busy_a, done_a}, 5'b0);
    chk("rst_async_b", {ifb.word_ready, chain_data_b, chain_enable_b, busy_b, done_b}, 5'b0);
    @(negedge clock);
    nreset = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_idle", {ifa.word_ready, chain_enable_a, busy_a, done_a}, 4'b0);
    ifa.word_valid = 1'b0;
    e0 = en_cnt_a;
    load_a(8'hA5, 0, dc, gc, ge, fo);
    exp_chain = {12{8'hA5}};
    chk("rst_reload_done_cycle", dc, 109);
    chk("rst_reload_chain", chain_a, exp_chain);

    chk("enable_low_data_low", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/config_chain_loader.md
Name: config_chain_loader

Overview:
Sequences the serial configuration shift chain that feeds the tile config registers.
- Accepts bitstream words from a host over a valid/ready handshake.
- Serialises each word MSB-first onto the chain data line, driving the chain's shift enable for exactly CHAIN_LENGTH cycles.
- Flags completion when the full chain is loaded.
- Sits between the bitstream source (SPI/JTAG front end) and the head of the chain. Its clock also drives config_clock of every tile.

Parameters:
WORD_WIDTH, 8, width of host bitstream words (>=2)
CHAIN_LENGTH, 96, total config bits in the chain (>=1, any value; need not be a multiple of WORD_WIDTH)
COUNT_WIDTH, $clog2(CHAIN_LENGTH+1), width of the bit counter

Ports:
clock  input  1  single clock; also the chain's config_clock
nreset  input  1  asynchronous active-low reset
start  input  1  begin a load; sampled in IDLE or DONE only
abort  input  1  cancel the current load
word_data  input  WORD_WIDTH  bitstream word
word_valid  input  1  word_data valid
word_ready  output  1  loader can accept a word
chain_data  output  1  serial bit to the chain head (config_in)
chain_enable  output  1  chain shift enable (config_enable)
chain_return  input  1  chain tail (last tile config_out)
busy  output  1  load in progress
done  output  1  full chain loaded; held until next start

Behaviour:
- Reset (async, nreset=0):
  - state=IDLE, bit counter=0, shift register=0.
  - word_ready=0, chain_data=0, chain_enable=0, busy=0, done=0.
  - Reset mid-load leaves the chain partially shifted; a fresh start is required.
- All outputs are registered.
- States: IDLE, WAIT_WORD, SHIFT, DONE.
- IDLE / DONE:
  - On start=1: load bits_left=CHAIN_LENGTH, clear done, go to WAIT_WORD.
  - start is ignored in WAIT_WORD/SHIFT.
- WAIT_WORD:
  - word_ready=1, busy=1.
  - On word_valid&&word_ready: capture word_data and set n = min(WORD_WIDTH, bits_left). Next cycle is SHIFT.
- SHIFT:
  - word_ready=0. chain_enable=1 for exactly n consecutive cycles.
  - chain_data = captured word bit WORD_WIDTH-1 in the first cycle, then bit WORD_WIDTH-2, and so on (MSB-first).
  - When bits_left<WORD_WIDTH (final partial word), only the top bits_left bits are shifted; the low bits are discarded.
  - bits_left decrements once per enabled cycle.
  - After the last bit: bits_left>0 -> WAIT_WORD; bits_left==0 -> DONE.
- DONE:
  - done=1, busy=0, chain_enable=0, word_ready=0.
  - Words offered in DONE/IDLE are not accepted.
- Throughput with word_valid held high: WORD_WIDTH+1 cycles per full word (1 accept + WORD_WIDTH shift).
- Latency: done rises the cycle after the final enabled shift cycle.
- abort=1 in any state except IDLE:
  - Next cycle: state=IDLE, chain_enable=0, word_ready=0, busy=0, done=0.
  - An in-flight shift stops immediately.
  - abort has priority over start and over a handshake in the same cycle.
- chain_enable=0 implies chain_data=0.
- chain_return is unused unless CONFIG_READBACK_EN is defined.

Optional Feature:
CONFIG_READBACK_EN
- Defined:
  - Adds outputs readback_data (WORD_WIDTH) and readback_valid (1).
  - On each enabled shift cycle, chain_return is sampled into a readback shift register (first sample lands at MSB after the word completes).
  - When a word's n bits are complete, readback_data presents them left-aligned, unused low bits 0, with a 1-cycle readback_valid pulse.
  - This streams out the previous chain contents during a load.
- Not defined: ports absent, no readback logic, chain_return unconnected internally.

Test Plan:
- Reset then idle: nreset low mid-SHIFT (chain_enable=1) -> all outputs 0 asynchronously; after release state IDLE, word_ready=0.
- Full load, defaults: start, 12 words 0xA5 with word_valid held -> chain_enable high 96 cycles total in 12 bursts of 8; chain_data pattern 1,0,1,0,0,1,0,1 per burst; done=1 at cycle 109 after start; busy low.
- Partial final word: CHAIN_LENGTH=20, WORD_WIDTH=8, words 0xFF,0x00,0xC3 -> bursts of 8,8,4 enabled cycles; last burst shifts 1,1,0,0; done after 20 enabled cycles total.
- Backpressure/gaps: word_valid low 5 cycles between words -> chain_enable stays 0 and word_ready stays 1 during the gap; no bits lost or duplicated (check 96 enabled cycles).
- Abort and start priority: abort asserted on 3rd shift cycle of word 4 -> chain_enable 0 next cycle, state IDLE, done=0. start during SHIFT -> ignored. Then a new start -> full 96-bit load succeeds.
- Readback (CONFIG_READBACK_EN): preload chain with 96 bits of 0x3C pattern, then load 0x00 words -> readback_valid pulses 12 times, each readback_data=0x3C.
